// File: rtl/test011_pkg.sv
// Shared field map, decode helper and state types for the test011 packed-result receiver.
package test011_pkg;

  localparam int Y_W    = 45;
  localparam int A0_LSB = 34;
  localparam int A0_W   = 4;
  localparam int NE_BIT = 25;
  localparam int LT_LSB = 21;
  localparam int LT_REP = 4;

  localparam logic [Y_W-1:0] RSVD_MASK = ~(45'h3C_0000_0000 | 45'h3E0_0000);

  // err_t bit positions
  localparam int ERR_RSVD = 0;
  localparam int ERR_REP  = 1;

  typedef logic [1:0] err_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  typedef enum logic [0:0] {
    CTL_RUN  = 1'b0,
    CTL_HALT = 1'b1
  } ctl_state_e;

  typedef struct packed {
    logic             ne;
    logic             lt;
    logic [A0_W-1:0]  a0;
    err_t             err;
  } dec_t;

  typedef struct packed {
    ctl_state_e ctl;
    buf_state_e bstate;
  } dbg_t;

  // lt is taken from the top replica even when the replicas disagree.
  function automatic dec_t decode(input logic [Y_W-1:0] y);
    dec_t             d;
    logic [LT_REP-1:0] rep;
    rep           = y[LT_LSB +: LT_REP];
    d.ne          = y[NE_BIT];
    d.lt          = y[LT_LSB + LT_REP - 1];
    d.a0          = y[A0_LSB +: A0_W];
    d.err         = '0;
    d.err[ERR_RSVD] = |(y & RSVD_MASK);
    d.err[ERR_REP]  = !((&rep) || !(|rep));
    return d;
  endfunction

endpackage

// File: rtl/test011_skid.sv
// Two-entry registered skid buffer; exposes its next-state FULL flag so the
// parent can register in_ready without a combinational path from out_ready.
module test011_skid
  import test011_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] data_o,
  output logic         full_d_o,
  output buf_state_e   state_o
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         pop;

  assign pop = (state_q != BUF_EMPTY) && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push_i) begin
          main_d  = data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push_i && pop) begin
          main_d = data_i;
        end else if (push_i) begin
          skid_d  = data_i;
          state_d = BUF_FULL;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        // push is never granted while FULL, so only the pop matters here
        if (pop) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_valid_o = (state_q != BUF_EMPTY);
  assign data_o      = main_q;
  assign full_d_o    = (state_d == BUF_FULL);
  assign state_o     = state_q;

endmodule

// File: rtl/test011_unpacker.sv
// Receive-side decoder for the test011 packed result word: decode, consistency
// checks, saturating counters, optional halt-on-error, registered skid output.
module test011_unpacker
  import test011_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ne,
  output logic             out_lt,
  output logic [A0_W-1:0]  out_a0,
  output err_t             out_err,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count,
  output logic             sticky_err,
  output dbg_t             dbg_state
);

  // Handshake: a word transfers on a rising edge where valid && ready; valid
  // and data hold until that edge, and ready never depends on valid.

  dec_t             dec;
  dec_t             out_dec;
  logic             accept;
  logic             dec_bad;
  logic             skid_full_d;
  buf_state_e       buf_state;

  ctl_state_e       ctl_q, ctl_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             sticky_q, sticky_d;

  assign dec     = decode(in_y);
  assign dec_bad = (dec.err != '0);
  assign accept  = in_valid && in_ready_q;

  test011_skid #(
    .W($bits(dec_t))
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .data_i      (dec),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .data_o      (out_dec),
    .full_d_o    (skid_full_d),
    .state_o     (buf_state)
  );

  always_comb begin
    ctl_d      = ctl_q;
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    sticky_d   = sticky_q;
    if (clr) begin
      ctl_d      = CTL_RUN;
      word_cnt_d = '0;
      err_cnt_d  = '0;
      sticky_d   = 1'b0;
    end else if (accept) begin
      if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
      if (dec_bad) begin
        sticky_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (STOP_ON_ERR) ctl_d = CTL_HALT;
      end
    end
    // in_ready is the registered image of next cycle's intake permission
    in_ready_d = (ctl_d == CTL_RUN) && !skid_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q      <= CTL_RUN;
      in_ready_q <= 1'b1;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
      sticky_q   <= 1'b0;
    end else begin
      ctl_q      <= ctl_d;
      in_ready_q <= in_ready_d;
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_ne           = out_dec.ne;
  assign out_lt           = out_dec.lt;
  assign out_a0           = out_dec.a0;
  assign out_err          = out_dec.err;
  assign word_count       = word_cnt_q;
  assign err_count        = err_cnt_q;
  assign sticky_err       = sticky_q;
  assign dbg_state.ctl    = ctl_q;
  assign dbg_state.bstate = buf_state;

endmodule

// File: doc/test011_unpacker.md
# test011_unpacker

Receive-side companion of the test011 packed result word. Accepts 45-bit packed words over a valid/ready handshake, decodes the mismatch flag, less-than flag and operand-echo fields, and checks reserved bits and flag replicas for consistency. It delivers decoded results downstream through a registered skid buffer and keeps saturating word and error counters. It optionally halts intake on the first malformed word.

## Interface
- `CNT_W`, default 16: width of `word_count` and `err_count`.
- `STOP_ON_ERR`, default 0: when 1, the first malformed word halts intake until `clr`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clr`  in  1  synchronous clear of the counters, `sticky_err` and the HALT state. Does not flush buffered data.
- `in_valid`  in  1  packed word valid.
- `in_ready`  out  1  driven directly from a register.
- `in_y`  in  45  packed word.
- `out_valid`  out  1  decoded result valid.
- `out_ready`  in  1  downstream accept.
- `out_ne`  out  1  mismatch flag, from `y[25]`.
- `out_lt`  out  1  less-than flag, from `y[24]`.
- `out_a0`  out  4  operand echo, from `y[37:34]`.
- `out_err`  out  2  bit0 = RSVD (a reserved bit is nonzero); bit1 = REP (`y[24:21]` is not all-equal).
- `word_count`  out  CNT_W  count of accepted words; saturates.
- `err_count`  out  CNT_W  count of accepted words with `out_err != 0`; saturates.
- `sticky_err`  out  1  set on the first error; cleared only by `rst` or `clr`.

## Operation
- **Field map:**
  - `y[37:34]` = a0.
  - `y[25]` = ne.
  - `y[24:21]` = lt replicated ×4.
  - Every other bit is reserved and must be 0. Reserved mask = `~(45'h3C_0000_0000 | 45'h3E0_0000)`.
- **Decode:** purely combinational on `in_y`, captured into a buffer entry on accept. An accept occurs when `in_valid && in_ready`.
  - `out_lt` takes `y[24]` even when REP is set.
- **Skid buffer:** two entries, main and skid. Buffer states:
  - EMPTY → ONE on accept without pop.
  - ONE → FULL on accept while `out_valid && !out_ready`.
  - FULL → ONE on pop.
  - ONE → EMPTY on pop without accept.
  - ONE stays ONE on simultaneous accept and pop.
- **Control FSM:**
  - RUN: `in_ready` = buffer not FULL, computed as a registered next-state value.
  - HALT: entered only when `STOP_ON_ERR=1` and a word with error is accepted. `in_ready=0`; the buffer still drains. HALT → RUN on `clr`.
- **Counters:**
  - Increment on accept, and saturate at all-ones.
  - `clr` zeroes them. `clr` coincident with an accept: the clear wins and the count becomes 0, not 1.
- **Reset:**
  - `in_ready` = 1 (0 during the `rst` cycle itself is acceptable; 1 from the next cycle).
  - `out_valid` = 0; `out_ne`, `out_lt`, `out_a0`, `out_err` = 0.
  - Counters = 0; `sticky_err` = 0; FSM = RUN; buffer = EMPTY.
  - Reset mid-transfer discards all buffered words with no output.

## Timing
- Latency: accept at edge N → `out_valid=1` with decoded fields after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle when `out_ready` is held 1.
- Outputs are stable while `out_valid && !out_ready`.
- `in_ready` drops the cycle after the buffer reaches FULL and rises the cycle after a pop from FULL. No combinational path from `out_ready` to `in_ready`.
- `word_count`, `err_count` and `sticky_err` update on the accept edge, so they are visible with `out_valid`.
- HALT takes effect from the cycle after the erroneous accept. A word offered in that same cycle is not accepted.

## Structure
- Package `test011_pkg`:
  - Field LSB/width constants: `A0_LSB=34`, `NE_BIT=25`, `LT_LSB=21`, `LT_REP=4`.
  - `RSVD_MASK`.
  - `err_t` (2-bit).
  - Buffer and FSM state enums.
  - Decoded-result struct `{ne, lt, a0, err}`.
- One sub-module, `test011_skid`: the 2-entry registered skid buffer, generic over payload width. The top holds the decode, counters and FSM.

## Test plan
- Word `45'h028_03E0_0000` with downstream always ready → `out_a0=4'hA`, `out_ne=1`, `out_lt=1`, `out_err=0`, one cycle later; `word_count=1`.
- Word `45'h0000_0060_0000` (lt replicas `4'b0011`) → `out_err=2'b10`, `err_count=1`, `sticky_err=1`.
- Word with `y[44]=1`, `STOP_ON_ERR=1` → `out_err=2'b01`. `in_ready=0` until `clr`; a word offered meanwhile is not consumed. After `clr`, intake resumes with `err_count=0`.
- `out_ready` held 0, three words offered back-to-back:
  - The first two are buffered; `in_ready=0` from the cycle after the second.
  - Releasing `out_ready` yields the words in order with no loss or duplication.
- `CNT_W=4`, 20 valid words → `word_count` saturates at `4'hF`.
- `rst` asserted while the buffer is FULL → next cycle `out_valid=0` and counters 0; no buffered word ever appears.
